stack_host: RTL and testbench

- Initiator-side controller for the `Stack` block. It converts a valid/ready command stream (push or pop) into `Stack` bus cycles on `push_pop`, `enable` and the shared tri-state `data_io`.
- It returns one response per command, carrying pop data or an error.
- It owns bus turnaround so host and `Stack` never drive `data_io` in the same cycle.
- It sits between a datapath requester and a `Stack` instance.

---
 rtl/stack_host_pkg.sv | 18 +
 rtl/stack_host_iobuf.sv | 24 ++
 rtl/stack_host.sv | 149 ++++++++++++++
 tb/tb_stack_host.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_host_pkg.sv
// Shared constants, default sizes and FSM state encoding for the stack host.
package stack_host_pkg;

  localparam logic OP_PUSH    = 1'b0;
  localparam logic OP_POP     = 1'b1;
  localparam int   DATA_W_DEF = 8;
  localparam int   DEPTH_DEF  = 1024;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP,
    CAP,
    TURN,
    ERR
  } state_t;

endpackage

// File: rtl/stack_host_iobuf.sv
// Tri-state driver for the shared Stack data bus and the pop-data capture register.
module stack_host_iobuf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drive_en,
  input  logic [DATA_W-1:0] out_data,
  input  logic              cap_en,
  output logic [DATA_W-1:0] cap_data,
  inout  wire  [DATA_W-1:0] data_io
);

  assign data_io = drive_en ? out_data : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_data <= '0;
    end else if (cap_en) begin
      cap_data <= data_io;
    end
  end

endmodule

// File: rtl/stack_host.sv
// Command-stream to Stack bus-cycle controller with explicit bus turnaround.
// Optional occupancy counter and `level` port under STACK_HOST_LEVEL_EN.
module stack_host
  import stack_host_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              push_pop,
  output logic              enable,
  inout  wire  [DATA_W-1:0] data_io,
  input  logic              full,
  input  logic              empty
`ifdef STACK_HOST_LEVEL_EN
  ,
  output logic [LEVEL_W-1:0] level
`endif
);

  state_t            state, state_nx;
  logic              last_op;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] cap_data;
  logic              rsp_pop;
  logic              accept;
  logic              is_full;
  logic              drive_en;
  logic              cap_en;

  assign accept = cmd_valid & cmd_ready;

`ifdef STACK_HOST_LEVEL_EN
  assign is_full = full | (level == LEVEL_W'(DEPTH));
`else
  assign is_full = full;
`endif

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    enable    = 1'b0;
    push_pop  = last_op;
    drive_en  = 1'b0;
    cap_en    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept) begin
          if ((cmd_op == OP_PUSH && is_full) || (cmd_op == OP_POP && empty))
            state_nx = ERR;
          else if (cmd_op == OP_POP)
            state_nx = POP;
          else if (last_op == OP_POP)
            state_nx = TURN;
          else
            state_nx = PUSH;
        end
      end
      TURN: begin
        push_pop = OP_PUSH;
        state_nx = PUSH;
      end
      PUSH: begin
        enable   = 1'b1;
        push_pop = OP_PUSH;
        drive_en = 1'b1;
        state_nx = IDLE;
      end
      POP: begin
        enable   = 1'b1;
        push_pop = OP_POP;
        state_nx = CAP;
      end
      CAP: begin
        push_pop = OP_POP;
        cap_en   = 1'b1;
        state_nx = IDLE;
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Reset releases the bus and blocks any strobe in the same cycle
    if (rst) begin
      cmd_ready = 1'b0;
      enable    = 1'b0;
      push_pop  = OP_POP;
      drive_en  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_op   <= OP_POP;
      data_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_pop   <= 1'b0;
    end else begin
      state     <= state_nx;
      if (accept)
        data_q <= cmd_data;
      rsp_valid <= (state == PUSH) || (state == CAP) || (state == ERR);
      rsp_err   <= (state == ERR);
      rsp_pop   <= (state == CAP);
      if (state == PUSH)
        last_op <= OP_PUSH;
      else if (state == POP)
        last_op <= OP_POP;
    end
  end

  assign rsp_data = rsp_pop ? cap_data : '0;

`ifdef STACK_HOST_LEVEL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else if (state == PUSH && level != LEVEL_W'(DEPTH)) begin
      level <= level + 1'b1;
    end else if (state == POP && level != '0) begin
      level <= level - 1'b1;
    end
  end
`endif

  stack_host_iobuf #(
    .DATA_W(DATA_W)
  ) u_iobuf (
    .clk      (clk),
    .rst      (rst),
    .drive_en (drive_en),
    .out_data (data_q),
    .cap_en   (cap_en),
    .cap_data (cap_data),
    .data_io  (data_io)
  );

endmodule

// File: tb/tb_stack_host.sv
// Bench for stack_host: behavioural Stack on the bus, reference stack and response scoreboard.
module tb_stack_host;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              push_pop;
  logic              enable;
  wire  [DATA_W-1:0] data_io;
  logic              full;
  logic              empty;
`ifdef STACK_HOST_LEVEL_EN
  logic [LEVEL_W-1:0] level;
`endif

  stack_host #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .push_pop  (push_pop),
    .enable    (enable),
    .data_io   (data_io),
    .full      (full),
    .empty     (empty)
`ifdef STACK_HOST_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Behavioural Stack device
  logic [DATA_W-1:0] mem [DEPTH];
  int                sp = 0;
  logic [DATA_W-1:0] stk_out = '0;
  logic              stk_drv = 1'b0;
  logic              full_mask = 1'b0;
  int                cyc = 0;
  int                en_cnt = 0;
  logic [DATA_W-1:0] last_wr = '0;

  assign data_io = stk_drv ? stk_out : {DATA_W{1'bz}};
  assign full    = (sp == DEPTH) & ~full_mask;
  assign empty   = (sp == 0);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    stk_drv <= enable & push_pop;
    if (enable) begin
      en_cnt <= en_cnt + 1;
      if (push_pop == 1'b0) begin
        if (sp < DEPTH) begin
          mem[sp] <= data_io;
          sp      <= sp + 1;
        end
        last_wr <= data_io;
      end else if (sp > 0) begin
        stk_out <= mem[sp-1];
        sp      <= sp - 1;
      end
    end
  end

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] data;
    int                lat;
    int                acc;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] ref_q[$];
  logic              ref_last = 1'b1;
  int                rsp_cnt = 0;
  int                turn_cnt = 0;
  int                contention = 0;

  always @(negedge clk) begin
    if (stk_drv && enable && !push_pop) contention++;
    if (!rst && !enable && !push_pop && !cmd_ready) turn_cnt++;
    if (rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_err", int'(rsp_err), int'(e.err));
        chk("rsp_data", int'(rsp_data), int'(e.data));
        chk("rsp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_cmd(input logic op, input logic [DATA_W-1:0] d);
    exp_t e;
    int   n;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    e.acc  = cyc;
    e.data = '0;
    if (op == 1'b0) begin
      if (ref_q.size() >= DEPTH) begin
        e.err = 1'b1;
        e.lat = 2;
      end else begin
        e.err = 1'b0;
        e.lat = ref_last ? 3 : 2;
        ref_q.push_back(d);
        ref_last = 1'b0;
      end
    end else begin
      if (ref_q.size() == 0) begin
        e.err = 1'b1;
        e.lat = 2;
      end else begin
        e.err    = 1'b0;
        e.lat    = 3;
        e.data   = ref_q.pop_back();
        ref_last = 1'b1;
      end
    end
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, e0, r0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_data  = '0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_push_pop", int'(push_pop), 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_enable", int'(enable), 0);
    chk("idle_push_pop", int'(push_pop), 1);
    chk("idle_cmd_ready", int'(cmd_ready), 1);
    chk("idle_no_rsp", rsp_cnt, 0);

`ifdef STACK_HOST_LEVEL_EN
    chk("level_reset", int'(level), 0);
    do_cmd(1'b0, 8'h01);
    do_cmd(1'b0, 8'h02);
    do_cmd(1'b0, 8'h03);
    chk("level_3", int'(level), 3);
    do_cmd(1'b1, 8'h00);
    do_cmd(1'b1, 8'h00);
    chk("level_1", int'(level), 1);
    do_cmd(1'b1, 8'h00);
    chk("level_0", int'(level), 0);
`endif

    // Push/pop with and without turnaround
    do_cmd(1'b0, 8'h11);
    t0 = turn_cnt;
    do_cmd(1'b0, 8'h2A);
    chk("push_no_turn", turn_cnt - t0, 0);
    chk("stack_write", int'(last_wr), 8'h2A);
    do_cmd(1'b1, 8'h00);
    t0 = turn_cnt;
    do_cmd(1'b0, 8'h55);
    chk("turn_cycles", turn_cnt - t0, 1);
    do_cmd(1'b1, 8'h00);
    do_cmd(1'b1, 8'h00);
    chk("empty_after", int'(empty), 1);

    // Reset during CAP: op stands, no response
    do_cmd(1'b0, 8'h77);
    wait_ready();
    r0 = rsp_cnt;
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    void'(ref_q.pop_back());
    ref_last  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_rsp", rsp_cnt - r0, 0);
    chk("abort_push_pop", int'(push_pop), 1);
    chk("abort_cmd_ready", int'(cmd_ready), 1);
    chk("abort_stack_popped", sp, 0);

    // Fill to full, overflow, drain, underflow
    for (int i = 0; i < DEPTH; i++) do_cmd(1'b0, DATA_W'(2 * i));
    chk("full_set", int'(full), 1);
    e0 = en_cnt;
    do_cmd(1'b0, 8'hEE);
    chk("overflow_no_enable", en_cnt - e0, 0);
`ifdef STACK_HOST_LEVEL_EN
    chk("level_depth", int'(level), DEPTH);
    full_mask = 1'b1;
    e0 = en_cnt;
    do_cmd(1'b0, 8'hDD);
    chk("level_full_no_enable", en_cnt - e0, 0);
    full_mask = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) do_cmd(1'b1, 8'h00);
    e0 = en_cnt;
    do_cmd(1'b1, 8'h00);
    chk("underflow_no_enable", en_cnt - e0, 0);

    chk("bus_contention", contention, 0);
    chk("sb_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
